// File: rtl/fp12_mult_arbiter.sv
// fp12_mult_arbiter: round-robin sharing of one pipelined fp12 multiplier among NUM_REQ requesters.
// Ports: clk/rst (sync, active-high); cfg_enable grants when 1, drains and halts when 0;
// req_valid/req_ready/req_a/req_b per-requester operand handshake (packed i*DATA_W);
// mult_a/mult_b/mult_valid_in registered issue to the multiplier; mult_result/mult_valid_out
// in-order results; rsp_valid/rsp_data one-hot routed response; busy; err_orphan sticky.
// Optional macro FP12_ARB_STATS_EN adds stat_sel/stat_count saturating per-requester grant counters.
module fp12_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 12,
  parameter int MAX_OUT = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mult_a,
  output logic [DATA_W-1:0]         mult_b,
  output logic                      mult_valid_in,
  input  logic [DATA_W-1:0]         mult_result,
  input  logic                      mult_valid_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
`ifdef FP12_ARB_STATS_EN
  input  logic [ID_W-1:0]           stat_sel,
  output logic [15:0]               stat_count,
`endif
  output logic                      err_orphan
);
  localparam int AW = $clog2(MAX_OUT);
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {HALTED, RUN, DRAIN} state_t;
  state_t state, state_d;
  logic [ID_W-1:0] ptr, gnt_id, cand;
  logic found, hs, pop;
  logic [OW-1:0] outstanding;
  logic [ID_W-1:0] tags [MAX_OUT];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign hs = |req_ready;
  // The tag FIFO occupancy always equals outstanding, so it doubles as the empty flag.
  assign pop = mult_valid_out && outstanding != '0;
  assign busy = outstanding != '0 || mult_valid_in;
  always_comb begin
    state_d = state == HALTED ? (cfg_enable ? RUN : HALTED) :
              cfg_enable ? RUN :
              (state == RUN || outstanding != '0 || mult_valid_in) ? DRAIN : HALTED;
    gnt_id = '0;
    found = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt_id = cand;
      end
    end
    req_ready = (state == RUN && outstanding < OW'(MAX_OUT) && found) ? NUM_REQ'(1) << gnt_id : '0;
  end
  always_ff @(posedge clk)
    if (rst) state <= HALTED;
    else state <= state_d;
  always_ff @(posedge clk)
    if (hs) tags[wr_ptr] <= gnt_id;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      outstanding <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mult_a <= '0;
      mult_b <= '0;
      mult_valid_in <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      err_orphan <= 1'b0;
    end else begin
      mult_valid_in <= hs;
      if (hs) begin
        mult_a <= DATA_W'(req_a >> (DATA_W * gnt_id));
        mult_b <= DATA_W'(req_b >> (DATA_W * gnt_id));
        wr_ptr <= wr_ptr + 1'b1;
        ptr <= 32'(gnt_id) == NUM_REQ - 1 ? '0 : gnt_id + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rsp_data <= mult_result;
      end
      outstanding <= outstanding + OW'(hs) - OW'(pop);
      rsp_valid <= pop ? NUM_REQ'(1) << tags[rd_ptr] : '0;
      if (mult_valid_out && outstanding == '0) err_orphan <= 1'b1;
    end
  end
`ifdef FP12_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
      stat_count <= '0;
    end else begin
      if (hs && cnt[gnt_id] != 16'hFFFF) cnt[gnt_id] <= cnt[gnt_id] + 1'b1;
      stat_count <= 32'(stat_sel) < NUM_REQ ? cnt[stat_sel] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_fp12_mult_arbiter.sv
// tb_fp12_mult_arbiter: scoreboard bench with a latency-configurable multiplier model and reference arbiter model.
module tb_fp12_mult_arbiter;
  localparam int N = 4, W = 12, MO = 4;
  logic clk = 1'b0, rst = 1'b1, cfg_enable = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] mult_a, mult_b, rsp_data, mult_result = '0;
  logic mult_valid_in, mult_valid_out = 1'b0, busy, err_orphan;
`ifdef FP12_ARB_STATS_EN
  logic [1:0] stat_sel = '0;
  logic [15:0] stat_count;
`endif
  fp12_mult_arbiter dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_valid_in(mult_valid_in),
    .mult_result(mult_result), .mult_valid_out(mult_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
`ifdef FP12_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_count(stat_count),
`endif
    .err_orphan(err_orphan));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Normal-range fp12 product, truncating the fraction.
  function automatic logic [11:0] fp_mul(input logic [11:0] a, input logic [11:0] b);
    int e, m;
    e = int'(a[10:6]) + int'(b[10:6]) - 15;
    m = (64 + int'(a[5:0])) * (64 + int'(b[5:0]));
    if (m >= 8192) begin
      m = m >> 1;
      e++;
    end
    e = e < 0 ? 0 : e > 31 ? 31 : e;
    return {a[11] ^ b[11], 5'(e), 6'(m >> 6)};
  endfunction
  typedef struct {int due; logic [11:0] r;} mq_t;
  typedef struct {int id; logic [11:0] d; int due;} ex_t;
  mq_t pipe[$];
  ex_t sb[$];
  int lat = 1;
  logic inj = 1'b0;
  int m_ptr = 0, m_out = 0;
  bit m_run = 0, m_mvi = 0, m_orphan = 0;
  logic [N-1:0] exp_rdy;
`ifdef FP12_ARB_STATS_EN
  int m_gcnt[N] = '{default: 0};
  int m_stat = 0;
`endif
  // Multiplier model and reference arbiter, evaluated mid-cycle.
  always @(negedge clk) begin : env
    int j, id;
    bit pop;
    mult_valid_out = inj;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      mult_valid_out = 1'b1;
      mult_result = pipe[0].r;
      void'(pipe.pop_front());
    end
    if (mult_valid_in) pipe.push_back('{cyc + 1 + lat, fp_mul(mult_a, mult_b)});
    exp_rdy = '0;
    id = 0;
    if (m_run && m_out < MO)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (exp_rdy == '0 && req_valid[j]) begin
          exp_rdy[j] = 1'b1;
          id = j;
        end
      end
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_out != 0 || m_mvi);
    chk("err_orphan", err_orphan, m_orphan);
`ifdef FP12_ARB_STATS_EN
    chk("stat_count", stat_count, m_stat);
`endif
    if (rst) begin
      m_run = 0; m_out = 0; m_ptr = 0; m_mvi = 0; m_orphan = 0;
`ifdef FP12_ARB_STATS_EN
      m_stat = 0;
      for (int k = 0; k < N; k++) m_gcnt[k] = 0;
`endif
    end else begin
      pop = mult_valid_out && m_out > 0;
      if (mult_valid_out && m_out == 0) m_orphan = 1;
`ifdef FP12_ARB_STATS_EN
      m_stat = m_gcnt[stat_sel];
`endif
      m_mvi = exp_rdy != '0;
      if (exp_rdy != '0) begin
        sb.push_back('{id, fp_mul(req_a[id*W +: W], req_b[id*W +: W]), cyc + 3 + lat});
        m_ptr = (id + 1) % N;
        m_out++;
`ifdef FP12_ARB_STATS_EN
        if (m_gcnt[id] < 65535) m_gcnt[id]++;
`endif
      end
      if (pop) m_out--;
      m_run = cfg_enable;
    end
  end
  always @(negedge clk) begin : mon
    ex_t e;
    if (rsp_valid != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 64'(1) << e.id);
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("rsp_missing", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (rst) sb.delete();
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 300; i++) begin
      if (!busy && sb.size() == 0 && pipe.size() == 0 && rsp_valid == '0) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout busy=%0b pending=%0d", busy, sb.size());
  endtask
  task automatic send(input int i, input logic [11:0] a, input logic [11:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    req_valid[i] = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout requester=%0d", i);
  endtask
  function automatic logic [11:0] rnd_op();
    return {1'($urandom), 5'($urandom_range(10, 20)), 6'($urandom)};
  endfunction
  initial begin
    int cnt, g, seq;
    tick(3);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_mvi", mult_valid_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    cfg_enable = 1'b1;
    tick();
    send(0, 12'h3C0, 12'h400);
    wait_idle();
    chk("basic_data", rsp_data, 12'h400);
    chk("basic_busy", busy, 0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 12'h3E0;
      req_b[i*W +: W] = 12'h400;
    end
    req_valid = '1;
    seq = 0;
    for (int t = 0; t < 20 && seq < 10; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
        chk("rr_order", g, seq % N);
        seq++;
      end
    end
    chk("rr_count", seq, 10);
    tick();
    req_valid = '0;
    wait_idle();
    chk("rr_data", rsp_data, 12'h420);
    lat = 8;
    req_valid = '1;
    cnt = 0;
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (req_ready != '0) cnt++;
    end
    chk("bp_grants", cnt, 4);
    @(negedge clk);
    chk("bp_regrant", req_ready != '0, 1);
    tick();
    req_valid = '0;
    wait_idle();
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    tick();
    cfg_enable = 1'b0;
    tick();
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("drain_no_grant", req_ready, 0);
    end
    chk("drain_busy", busy, 1);
    tick();
    cfg_enable = 1'b1;
    tick();
    @(negedge clk);
    chk("drain_resume", req_ready != '0, 1);
    tick();
    req_valid = '0;
    cfg_enable = 1'b0;
    wait_idle();
    chk("drain_idle", busy, 0);
    cfg_enable = 1'b1;
    lat = 1;
    tick(2);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    chk("orphan_set", err_orphan, 1);
    chk("orphan_rsp", rsp_valid, 0);
    tick();
    lat = 8;
    req_a[W +: 2*W] = {rnd_op(), rnd_op()};
    req_b[W +: 2*W] = {rnd_op(), rnd_op()};
    req_valid = 4'b0110;
    tick(2);
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_mult_a", mult_a, 0);
    chk("midrst_mult_b", mult_b, 0);
    chk("midrst_mvi", mult_valid_in, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_orphan", err_orphan, 0);
    chk("midrst_busy", busy, 0);
    tick(14);
    chk("late_orphan", err_orphan, 1);
    wait_idle();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 6);
      for (int t = 0; t < 150; t++) begin
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
          req_a[i*W +: W] = rnd_op();
          req_b[i*W +: W] = rnd_op();
        end
        cfg_enable = $urandom_range(0, 9) != 0;
        tick();
      end
      req_valid = '0;
      cfg_enable = 1'b1;
      wait_idle();
    end
`ifdef FP12_ARB_STATS_EN
    do_reset();
    lat = 1;
    stat_sel = 2'd2;
    for (int i = 0; i < 5; i++) send(2, rnd_op(), rnd_op());
    wait_idle();
    tick(2);
    chk("stat_five", stat_count, 5);
    stat_sel = 2'd0;
    req_valid = 4'b0001;
    tick(70000);
    req_valid = '0;
    wait_idle();
    tick(2);
    chk("stat_sat", stat_count, 16'hFFFF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp12_mult_arbiter.md
Name: fp12_mult_arbiter

Overview:
- Shares one pipelined fp12 multiplier between NUM_REQ requesters using round-robin arbitration.
- fp12 format: sign[11], exp[10:6] with bias 15, frac[5:0].
- Captures the winning operand pair into registered multiplier inputs and tracks the requester ID of every in-flight operation in a tag FIFO.
- Routes each multiplier result back to its originating requester.
- Sits between the vector/accumulate front-end and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 12, operand/result width (fp12).
- MAX_OUT, 4, maximum in-flight operations; also the tag FIFO depth (power of 2).
- ID_W, $clog2(NUM_REQ), local; requester tag width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_enable  in  1  1 = grant new requests; 0 = drain and halt.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero; combinational.
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing.
- mult_a  out  DATA_W  registered operand A to the multiplier.
- mult_b  out  DATA_W  registered operand B to the multiplier.
- mult_valid_in  out  1  registered issue strobe to the multiplier.
- mult_result  in  DATA_W  multiplier result.
- mult_valid_out  in  1  multiplier result strobe; results return in issue order.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_data  out  DATA_W  registered result, shared bus.
- busy  out  1  high while any operation is in flight or being issued.
- err_orphan  out  1  sticky; set by a result arriving while the tag FIFO is empty.

Behaviour:
- Reset values:
  - req_ready, mult_a, mult_b, mult_valid_in, rsp_valid, rsp_data, err_orphan = 0.
  - RR pointer = 0, outstanding = 0, FIFO empty, state = HALTED.
- States:
  - HALTED -> RUN when cfg_enable=1.
  - RUN -> DRAIN when cfg_enable=0.
  - DRAIN -> HALTED when outstanding==0 and mult_valid_in==0.
  - DRAIN -> RUN if cfg_enable returns to 1 first.
- Grant rule:
  - Grants only in RUN with outstanding < MAX_OUT.
  - req_ready asserts for the first valid requester searching upward from the pointer, wrapping modulo NUM_REQ.
  - A handshake occurs when req_valid[i] & req_ready[i]. At most one handshake per cycle.
  - req_ready is never asserted to a requester with req_valid=0.
- On a handshake with requester i:
  - Next cycle: mult_a/mult_b carry requester i's operands and mult_valid_in=1.
  - i is pushed to the tag FIFO.
  - outstanding increments.
  - Pointer becomes (i+1) mod NUM_REQ.
  - With no handshake, mult_valid_in=0 next cycle, mult_a/mult_b hold their values, and the pointer holds.
- On mult_valid_out:
  - Pop tag t.
  - Next cycle: rsp_valid[t]=1 for exactly 1 cycle and rsp_data = mult_result.
  - outstanding decrements.
- Simultaneous issue and return in one cycle: outstanding unchanged; FIFO push and pop both occur.
- mult_valid_out with an empty FIFO: no pop, no rsp_valid, err_orphan=1 until rst.
- End-to-end latency with multiplier latency L: rsp_valid rises L+2 cycles after the handshake edge. With L=1, that is 3 cycles.
- Full: at outstanding==MAX_OUT, req_ready=0. A return in that same cycle does not re-enable a grant until the next cycle.
- Requesters may drop req_valid before being granted; no penalty.
- Reset mid-operation:
  - All state clears, in-flight tags are discarded, and the state returns to HALTED.
  - Late multiplier results after reset set err_orphan.
- busy = (outstanding != 0) | mult_valid_in.

Optional Feature:
- Macro FP12_ARB_STATS_EN adds:
  - Input stat_sel (ID_W).
  - Output stat_count (16).
  - One saturating 16-bit grant counter per requester, incremented on each handshake, cleared by rst, capped at 0xFFFF.
  - stat_count = counter[stat_sel], registered with 1-cycle latency.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic path: rst, cfg_enable=1, requester 0 sends a=0x3C0 (1.0), b=0x400 (2.0); bench multiplier model L=1 -> rsp_valid[0] 3 cycles after the handshake, rsp_data=0x400, busy low afterwards.
- Round-robin: all 4 requesters hold valid continuously, MAX_OUT=4, L=1 -> grant order 0,1,2,3,0,1,...; each rsp_valid matches its requester. Operands 0x3E0 (1.5) x 0x400 return 0x420 (3.0).
- Backpressure: L=8 model, all requesters valid -> exactly 4 grants, then req_ready=0 until the first return; the next grant comes one cycle after that return. outstanding never exceeds 4.
- Drain: 3 operations in flight, drop cfg_enable -> no new req_ready; all 3 responses delivered; HALTED when busy falls. Raising cfg_enable during DRAIN resumes grants.
- Orphan and reset: pulse mult_valid_out with nothing in flight -> err_orphan=1, no rsp_valid. Assert rst with 2 operations in flight -> all outputs 0 next cycle, err_orphan cleared.
- FP12_ARB_STATS_EN: 5 grants to requester 2, stat_sel=2 -> stat_count=5 one cycle later; force 70000 grants -> stat_count holds 0xFFFF.
